// File: rtl/chart_recorder.sv
// chart_recorder -- writer side of the chart memory.
//
// Samples the player's up/down buttons once per beat slot and writes one
// note word per slot (2 bits per lane: 00 empty, 01 tap, 10 hold,
// 11 end marker) to the chart RAM. The word format matches playback, so a
// recorded chart plays back unchanged.
//
// Optional build macro: CHART_REC_TERMINATOR_EN
//   When defined, every RECORD->DONE exit that did not fill the chart
//   issues one extra write on the following cycle: wr_addr=chart_len,
//   both codes 11. chart_len itself excludes this terminator.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start, stop         one-cycle control pulses
//   beat_tick           one-cycle pulse at each slot boundary
//   clickup, clickdown  debounced button levels, active-high
//   wr_en, wr_addr      RAM write strobe / address
//   wr_noteup/notedown  lane note codes for the write
//   recording, done     registered state decodes
//   chart_len           slots written by the last recording
module chart_recorder #(
   parameter int ADDR_W   = 12,
   parameter int MAX_ADDR = 4095
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              beat_tick,
   input  logic              clickup,
   input  logic              clickdown,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [1:0]        wr_noteup,
   output logic [1:0]        wr_notedown,
   output logic              recording,
   output logic              done,
   output logic [ADDR_W:0]   chart_len
);

   typedef enum logic [1:0] {IDLE, RECORD, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic              prev_up, prev_dn;
   logic              latch_up, latch_dn;
   logic [1:0]        last_up, last_dn;
   logic              rise_up, rise_dn;
   logic              slot_close, at_max, rec_start;
   logic [1:0]        code_up, code_dn;

   // A press seen anywhere in the slot (including on the closing cycle)
   // is a tap; a held button only continues a note that already exists.
   function automatic logic [1:0] lane_code(input logic pressed,
                                            input logic level,
                                            input logic [1:0] last);
      if (pressed)
         lane_code = 2'b01;
      else if (level && (last == 2'b01 || last == 2'b10))
         lane_code = 2'b10;
      else
         lane_code = 2'b00;
   endfunction

   always_comb begin
      rise_up    = clickup & ~prev_up;
      rise_dn    = clickdown & ~prev_dn;
      slot_close = (state == RECORD) && beat_tick;
      at_max     = (addr == ADDR_W'(MAX_ADDR));
      code_up    = lane_code(latch_up | rise_up, clickup, last_up);
      code_dn    = lane_code(latch_dn | rise_dn, clickdown, last_dn);
      state_nxt  = state;
      rec_start  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = RECORD;
               rec_start = 1'b1;
            end
         end
         RECORD: begin
            if (stop || (slot_close && at_max))
               state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef CHART_REC_TERMINATOR_EN
   logic term_pend;

   always_ff @(posedge clk) begin
      if (rst)
         term_pend <= 1'b0;
      else
         // full stop (tick at the last address) gets no terminator
         term_pend <= (state == RECORD) && (state_nxt == DONE) &&
                      !(slot_close && at_max);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         addr        <= '0;
         prev_up     <= 1'b0;
         prev_dn     <= 1'b0;
         latch_up    <= 1'b0;
         latch_dn    <= 1'b0;
         last_up     <= 2'b00;
         last_dn     <= 2'b00;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_noteup   <= 2'b00;
         wr_notedown <= 2'b00;
         recording   <= 1'b0;
         done        <= 1'b0;
         chart_len   <= '0;
      end else begin
         state     <= state_nxt;
         recording <= (state_nxt == RECORD);
         done      <= (state_nxt == DONE);
         prev_up   <= clickup;
         prev_dn   <= clickdown;
         wr_en     <= 1'b0;
         if (rec_start) begin
            addr      <= '0;
            latch_up  <= 1'b0;
            latch_dn  <= 1'b0;
            last_up   <= 2'b00;
            last_dn   <= 2'b00;
            chart_len <= '0;
         end else if (state == RECORD) begin
            if (slot_close) begin
               wr_en       <= 1'b1;
               wr_addr     <= addr;
               wr_noteup   <= code_up;
               wr_notedown <= code_dn;
               last_up     <= code_up;
               last_dn     <= code_dn;
               latch_up    <= 1'b0;
               latch_dn    <= 1'b0;
               if (at_max)
                  chart_len <= (ADDR_W+1)'(MAX_ADDR + 1);
               else begin
                  addr <= addr + 1'b1;
                  if (stop)
                     chart_len <= {1'b0, addr} + (ADDR_W+1)'(1);
               end
            end else begin
               latch_up <= latch_up | rise_up;
               latch_dn <= latch_dn | rise_dn;
               // stop without a tick drops the partial slot
               if (stop)
                  chart_len <= {1'b0, addr};
            end
         end
`ifdef CHART_REC_TERMINATOR_EN
         // chart_len was settled on the exit edge, so it is the next free slot
         if (term_pend) begin
            wr_en       <= 1'b1;
            wr_addr     <= chart_len[ADDR_W-1:0];
            wr_noteup   <= 2'b11;
            wr_notedown <= 2'b11;
         end
`endif
      end
   end

endmodule

// File: tb/tb_chart_recorder.sv
// Bench for chart_recorder: directed test-plan scenarios followed by random
// stimulus, all checked cycle by cycle against a slot-level model.
module tb_chart_recorder;
   localparam int AW = 4;
   localparam int MAXA = 6;

   logic clk = 1'b0;
   logic rst, start, stop, beat_tick, clickup, clickdown;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [1:0]    wr_noteup, wr_notedown;
   logic          recording, done;
   logic [AW:0]   chart_len;

   int checks = 0;
   int failures = 0;

   chart_recorder #(.ADDR_W(AW), .MAX_ADDR(MAXA)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .beat_tick(beat_tick),
      .clickup(clickup), .clickdown(clickdown), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_noteup(wr_noteup), .wr_notedown(wr_notedown), .recording(recording),
      .done(done), .chart_len(chart_len));

   always #5 clk = ~clk;

   // model: the recorder seen as "slot in progress" with per-lane facts
   bit m_rec, m_done, m_term, pressed[2], prev[2];
   int m_addr, m_len, last[2];
   bit e_wr;
   int e_addr, e_code[2];

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int note_for(bit press, bit level, int prior);
      if (press) return 1;
      if (level && (prior == 1 || prior == 2)) return 2;
      return 0;
   endfunction

   task automatic step(input bit r, input bit s, input bit p, input bit t,
                       input bit u, input bit d);
      bit lvl[2];
      bit rise[2];
      @(negedge clk);
      rst = r; start = s; stop = p; beat_tick = t; clickup = u; clickdown = d;
      lvl[0] = u; lvl[1] = d;
      for (int i = 0; i < 2; i++) rise[i] = lvl[i] && !prev[i];
      e_wr = 0;
      if (r) begin
         m_rec = 0; m_done = 0; m_term = 0; m_addr = 0; m_len = 0;
         for (int i = 0; i < 2; i++) begin pressed[i] = 0; prev[i] = 0; last[i] = 0; end
      end else begin
`ifdef CHART_REC_TERMINATOR_EN
         if (m_term) begin
            e_wr = 1; e_addr = m_len; e_code[0] = 3; e_code[1] = 3;
         end
`endif
         m_term = 0;
         if (m_rec) begin
            if (t) begin
               e_wr = 1; e_addr = m_addr;
               for (int i = 0; i < 2; i++) begin
                  e_code[i] = note_for(pressed[i] || rise[i], lvl[i], last[i]);
                  last[i] = e_code[i];
                  pressed[i] = 0;
               end
               if (m_addr == MAXA) begin
                  m_rec = 0; m_done = 1; m_len = MAXA + 1;
               end else begin
                  m_addr++;
                  if (p) begin m_rec = 0; m_done = 1; m_len = m_addr; m_term = 1; end
               end
            end else begin
               for (int i = 0; i < 2; i++) pressed[i] |= rise[i];
               if (p) begin m_rec = 0; m_done = 1; m_len = m_addr; m_term = 1; end
            end
         end else if (s) begin
            m_rec = 1; m_done = 0; m_addr = 0; m_len = 0;
            for (int i = 0; i < 2; i++) begin pressed[i] = 0; last[i] = 0; end
         end
         for (int i = 0; i < 2; i++) prev[i] = lvl[i];
      end
      @(posedge clk);
      #1;
      chk("wr_en", wr_en, e_wr);
      if (e_wr) begin
         chk("wr_addr", wr_addr, e_addr);
         chk("wr_noteup", wr_noteup, e_code[0]);
         chk("wr_notedown", wr_notedown, e_code[1]);
      end
      chk("recording", recording, m_rec);
      chk("done", done, m_done);
      chk("chart_len", chart_len, m_len);
   endtask

   initial begin
      bit u, d;
      rst = 1; start = 0; stop = 0; beat_tick = 0; clickup = 0; clickdown = 0;
      m_rec = 0; m_done = 0; m_term = 0; m_addr = 0; m_len = 0;
      for (int i = 0; i < 2; i++) begin pressed[i] = 0; prev[i] = 0; last[i] = 0; end
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("reset_wr_addr", wr_addr, 0);
      // up tap in slot 0, down pressed and held through tick 2
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0, 1);   // addr0 up=01 down=01
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0, 1);   // addr1 00/10
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0, 1);   // addr2 00/10
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);   // addr3 00/00
      // rising edge on the tick cycle belongs to the closing slot
      step(0, 0, 0, 1, 1, 0);   // addr4 01
      step(0, 0, 0, 1, 1, 0);   // addr5 10
      step(0, 0, 0, 1, 1, 0);   // addr6 full -> DONE, len 7
      step(0, 0, 0, 1, 0, 0);   // ignored tick
      step(0, 0, 1, 0, 0, 0);   // ignored stop
      step(0, 0, 0, 0, 0, 0);
      // stop together with tick at address 2
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 1, 1, 0, 0);   // addr2 written, len 3
      step(0, 0, 0, 0, 0, 0);   // terminator (if enabled)
      step(0, 0, 0, 0, 0, 0);
      // stop without tick drops the partial slot
      step(0, 1, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 1, 0);   // len 1
      step(0, 0, 0, 0, 0, 0);
      // reset the cycle after a tick
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 1);   // records from address 0 again
      step(0, 0, 0, 0, 0, 0);
      // random traffic
      u = 0; d = 0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 4) == 0) u = ~u;
         if ($urandom_range(0, 4) == 0) d = ~d;
         step($urandom_range(0, 199) == 0, $urandom_range(0, 14) == 0,
              $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, u, d);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/chart_recorder.md
Name: chart_recorder

Overview:
- Chart authoring block: samples the player's up/down buttons once per beat slot and writes one 2-bit-per-lane note word per slot to a chart RAM.
- It is the writer side of the chart memory that the playback address generator and chart ROM read. Its output word format is identical to the playback format, so a recorded chart can be loaded and played back unchanged.
- Single clock domain: beat timing comes in as a one-cycle pulse, not as a divided clock.

Parameters:
- ADDR_W, 12, chart address width (matches the playback address).
- MAX_ADDR, 4095, last writable slot address; must be < 2^ADDR_W.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a recording at address 0.
- stop  in  1  one-cycle pulse; ends a recording.
- beat_tick  in  1  one-cycle pulse at each slot boundary (edge of the divided beat clock).
- clickup  in  1  debounced up-lane button level, active-high.
- clickdown  in  1  debounced down-lane button level, active-high.
- wr_en  out  1  RAM write strobe, one cycle per slot.
- wr_addr  out  ADDR_W  RAM write address.
- wr_noteup  out  2  up-lane note code.
- wr_notedown  out  2  down-lane note code.
- recording  out  1  high while in RECORD.
- done  out  1  high while in DONE.
- chart_len  out  ADDR_W+1  number of slots written by the last recording.

Behaviour:
- Note codes (per lane): 00 empty, 01 tap, 10 hold, 11 end marker (written only by the optional feature).
- Reset (sync, active-high) sets:
  - state=IDLE and the internal slot address to 0;
  - all press latches and previous-button registers to 0;
  - the last-code register of each lane to 00;
  - all outputs (wr_en, wr_addr, wr_noteup, wr_notedown, recording, done, chart_len) to 0.
- Reset wins over every other input on the same edge.
- States: IDLE, RECORD, DONE.
  - IDLE: start → RECORD, with address=0, latches cleared and last codes=00.
  - RECORD: start is ignored.
  - DONE: start → RECORD as in IDLE; chart_len holds until that start edge.
- Edge detection: per-lane registered copy of the button; rising edge = level & ~prev. Rising edges during RECORD set that lane's press latch.
- Slot close, on a beat_tick edge while in RECORD. The lane code is:
  - 01 if the latch is set or a rising edge occurs on the same cycle (a same-cycle press belongs to the closing slot);
  - else 10 if the level is high and the lane's last code is 01 or 10;
  - else 00.
- On the slot-close edge:
  - register wr_en=1, wr_addr=address, and both lane codes;
  - update the last codes;
  - clear the latches.
  - So wr_en is high for exactly the one cycle after the tick (latency 1), and wr_en is 0 in every other cycle.
- Address and full condition:
  - If address==MAX_ADDR at slot close: the write happens, chart_len=MAX_ADDR+1, state → DONE.
  - Otherwise address increments by 1.
  - No wrap-around.
- stop in RECORD:
  - Without beat_tick: state → DONE, chart_len=address. The partial slot is discarded.
  - Together with beat_tick: the slot is written first, then DONE, chart_len=address+1.
- stop in IDLE or DONE: ignored.
- beat_tick outside RECORD: ignored, no write.
- recording and done are registered state decodes and update on the edge that changes state.
- Reset mid-recording: any in-flight wr_en is dropped the next cycle; no further writes occur.

Optional Feature:
- CHART_REC_TERMINATOR_EN defined:
  - On every RECORD→DONE transition with chart_len < MAX_ADDR+1, one extra write occurs in the following cycle: wr_addr=chart_len, both codes 11.
  - This is a registered second write, so wr_en may be high for two consecutive cycles.
  - chart_len excludes the terminator.
  - No terminator is written on a full stop.
- Undefined: no terminator write; codes are limited to 00/01/10.

Test Plan:
- Start; press up (rising edge) within slot 0; give 3 ticks → writes at addr 0/1/2 with up=01/00/00, down=00/00/00; wr_en lasts one cycle, one cycle after each tick.
- Press down before tick 0 and keep it held through tick 2 → down codes 01, 10, 10; release before tick 3 → 00.
- Rising edge of clickup on the same cycle as beat_tick → counted in the closing slot (01), not the next one; the next slot is 10 if still held, else 00.
- MAX_ADDR=3; record 4 ticks → addresses 0..3 written, done=1, chart_len=4; a 5th tick produces no write.
- stop together with tick at address 2 → slot 2 written, chart_len=3. With CHART_REC_TERMINATOR_EN: the next cycle writes addr 3 with codes 11/11.
- rst asserted the cycle after a tick in RECORD → wr_en=0, recording=0, chart_len=0 on the next edge; a subsequent start records from address 0.
